// File: rtl/vga_timing_gen_if.sv
// Pixel request bus between the raster generator and an upstream pixel source.
// The generator asks for (px_x, px_y) with request; the source answers on color.
interface vga_timing_gen_if #(
    parameter int COLOR_W = 8,
    parameter int CNT_W   = 10
);
    logic               request;
    logic [CNT_W-1:0]   px_x;
    logic [CNT_W-1:0]   px_y;
    logic [COLOR_W-1:0] color;

    modport master (output request, px_x, px_y, input color);
    modport slave  (input request, px_x, px_y, output color);
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: pixel-rate tick, h/v counters, pixel requests,
// test patterns and registered rgb/sync/data-enable outputs.
//
// state   | meaning
// ST_IDLE | en low or just out of reset; counters parked at tick 0 of (0,0)
// ST_RUN  | raster advancing one tick per clk
module vga_timing_gen #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int CLK_DIV         = 4,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int COLOR_W         = 8,
    parameter int CNT_W           = 10,
    parameter int CHK_BIT         = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    vga_timing_gen_if.master   pix,
    output logic [COLOR_W-1:0] rgb,
    output logic               h_sync,
    output logic               v_sync,
    output logic               active,
    output logic               line_start,
    output logic               frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int TICK_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]  V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]  H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0]  H_SYNC_ON  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0]  H_SYNC_OFF = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0]  V_SYNC_ON  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0]  V_SYNC_OFF = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic              SYNC_IDLE  = (SYNC_ACTIVE_LOW != 0);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t             state;
    logic [TICK_W-1:0]  tick, tick_n;
    logic [CNT_W-1:0]   hc, hc_n;
    logic [CNT_W-1:0]   vc, vc_n;
    logic [1:0]         mode_q;
    logic               line_n, frame_n, req_n;
    logic               in_act, hs_on, vs_on;
    logic [CNT_W+2:0]   hx8;
    logic [2:0]         bar_idx;
    logic [COLOR_W-1:0] bar_rgb;
    logic [COLOR_W-1:0] pix_rgb;

    always_comb begin
        tick_n = tick;
        hc_n   = hc;
        vc_n   = vc;
        if (!en || state == ST_IDLE) begin
            tick_n = '0;
            hc_n   = '0;
            vc_n   = '0;
        end else if (tick != TICK_LAST) begin
            tick_n = tick + 1'b1;
        end else begin
            tick_n = '0;
            if (hc == H_LAST) begin
                hc_n = '0;
                vc_n = (vc == V_LAST) ? '0 : vc + 1'b1;
            end else begin
                hc_n = hc + 1'b1;
            end
        end
    end

    // Pulses and requests are registered from the next position so they line up with it.
    always_comb begin
        line_n  = en && (tick_n == '0) && (hc_n == '0);
        frame_n = line_n && (vc_n == '0);
        req_n   = en && (tick_n == '0) && (hc_n < H_ACT) && (vc_n < V_ACT)
                  && ((frame_n ? mode : mode_q) == 2'd0);
    end

    assign in_act = (hc < H_ACT) && (vc < V_ACT);
    assign hs_on  = (hc >= H_SYNC_ON) && (hc < H_SYNC_OFF);
    assign vs_on  = (vc >= V_SYNC_ON) && (vc < V_SYNC_OFF);
    assign hx8    = {hc, 3'b000};

    // Bar index floor(hc*8/H_ACTIVE) as a count of crossed thresholds, no divider needed.
    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (hx8 >= (CNT_W+3)'(k * H_ACTIVE)) bar_idx = bar_idx + 3'd1;
        end
    end

    for (genvar b = 0; b < COLOR_W; b++) begin : g_bar
        assign bar_rgb[b] = bar_idx[b % 3];
    end

    always_comb begin
        pix_rgb = '0;
        if (in_act) begin
            case (mode_q)
                2'd0:    pix_rgb = pix.color;
                2'd1:    pix_rgb = '1;
                2'd2:    pix_rgb = {COLOR_W{hc[CHK_BIT] ^ vc[CHK_BIT]}};
                default: pix_rgb = bar_rgb;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            tick        <= '0;
            hc          <= '0;
            vc          <= '0;
            mode_q      <= 2'd0;
            pix.request <= 1'b0;
            pix.px_x    <= '0;
            pix.px_y    <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            rgb         <= '0;
            active      <= 1'b0;
            h_sync      <= SYNC_IDLE;
            v_sync      <= SYNC_IDLE;
        end else begin
            state       <= en ? ST_RUN : ST_IDLE;
            tick        <= tick_n;
            hc          <= hc_n;
            vc          <= vc_n;
            line_start  <= line_n;
            frame_start <= frame_n;
            pix.request <= req_n;
            if (frame_n) mode_q <= mode;
            if (req_n) begin
                pix.px_x <= hc_n;
                pix.px_y <= vc_n;
            end
            if (!en) begin
                rgb    <= '0;
                active <= 1'b0;
                h_sync <= SYNC_IDLE;
                v_sync <= SYNC_IDLE;
            end else if (state == ST_RUN && tick == TICK_LAST) begin
                rgb    <= pix_rgb;
                active <= in_act;
                h_sync <= hs_on ? ~SYNC_IDLE : SYNC_IDLE;
                v_sync <= vs_on ? ~SYNC_IDLE : SYNC_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster: per-cycle comparison against a
// position-in-frame reference model, a pixel-colour table and directed corner cases.
module tb_vga_timing_gen;
    localparam int HA = 16, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
    localparam int CD = 3, CW = 8, NW = 6, CHK = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME_CLK = HT * VT * CD;

    logic clk = 1'b0;
    logic rst, en;
    logic [1:0] mode;
    logic [CW-1:0] rgb;
    logic h_sync, v_sync, active, line_start, frame_start;

    vga_timing_gen_if #(.COLOR_W(CW), .CNT_W(NW)) pix ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(CD), .SYNC_ACTIVE_LOW(1), .COLOR_W(CW), .CNT_W(NW), .CHK_BIT(CHK)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .pix(pix),
        .rgb(rgb), .h_sync(h_sync), .v_sync(v_sync), .active(active),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    bit chk_on = 1'b0;

    // Reference state: clocks elapsed since tick 0 of (0,0), the frame's mode, last requested pixel.
    bit m_run = 1'b0;
    int m_t = 0, fmode = 0, m_px_x = 0, m_px_y = 0;

    typedef struct { int md; int x; int y; int rgb; int act; } vec_t;
    vec_t tbl[18];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int f_col(input int x, input int y);
        return (y * 16 + x) & 255;
    endfunction

    function automatic int colour_of(input int md, input int x, input int y);
        int i, r;
        if (!(x < HA && y < VA)) return 0;
        case (md)
            0: return f_col(x, y);
            1: return 255;
            2: return ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) ? 255 : 0;
            default: begin
                i = x * 8 / HA;
                r = 0;
                for (int b = 0; b < CW; b++) if (((i >> (b % 3)) & 1) != 0) r |= (1 << b);
                return r;
            end
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 1'b0; m_t = 0; fmode = 0; m_px_x = 0; m_px_y = 0;
        end else if (!en) begin
            m_run = 1'b0;
        end else begin
            if (!m_run) begin m_run = 1'b1; m_t = 0; end
            else m_t = (m_t + 1) % FRAME_CLK;
            if (m_t == 0) fmode = int'(mode);
            if (fmode == 0 && m_t % CD == 0 && (m_t / CD) % HT < HA && (m_t / CD) / HT < VA) begin
                m_px_x = (m_t / CD) % HT;
                m_px_y = (m_t / CD) / HT;
            end
        end
    end

    // Pixel source: valid data only on the sample cycle, noise otherwise.
    always @(negedge clk) begin
        if (m_run && (m_t % CD) == CD - 1) pix.color = CW'(f_col(int'(pix.px_x), int'(pix.px_y)));
        else pix.color = CW'($urandom);
    end

    always @(negedge clk) begin : cyc_chk
        int tk, p, hc, vc, hcp, vcp;
        int e_req, e_ls, e_fs, e_rgb, e_act, e_hs, e_vs;
        if (chk_on) begin
            e_req = 0; e_ls = 0; e_fs = 0; e_rgb = 0; e_act = 0; e_hs = 1; e_vs = 1;
            if (m_run) begin
                tk = m_t % CD; p = m_t / CD; hc = p % HT; vc = p / HT;
                e_req = (fmode == 0 && tk == 0 && hc < HA && vc < VA) ? 1 : 0;
                e_ls  = (tk == 0 && hc == 0) ? 1 : 0;
                e_fs  = (e_ls == 1 && vc == 0) ? 1 : 0;
                if (p > 0) begin
                    hcp = (p - 1) % HT; vcp = (p - 1) / HT;
                    e_rgb = colour_of(fmode, hcp, vcp);
                    e_act = (hcp < HA && vcp < VA) ? 1 : 0;
                    e_hs  = (hcp >= HA + HF && hcp < HA + HF + HS) ? 0 : 1;
                    e_vs  = (vcp >= VA + VF && vcp < VA + VF + VS) ? 0 : 1;
                end
            end
            check("cyc_request", int'(pix.request), e_req);
            check("cyc_px_x", int'(pix.px_x), m_px_x);
            check("cyc_px_y", int'(pix.px_y), m_px_y);
            check("cyc_line_start", int'(line_start), e_ls);
            check("cyc_frame_start", int'(frame_start), e_fs);
            check("cyc_rgb", int'(rgb), e_rgb);
            check("cyc_active", int'(active), e_act);
            check("cyc_h_sync", int'(h_sync), e_hs);
            check("cyc_v_sync", int'(v_sync), e_vs);
        end
    end

    task automatic restart(input int md);
        @(negedge clk); en = 1'b0; mode = 2'(md);
        @(negedge clk); en = 1'b1;
    endtask

    task automatic wait_t(input int target, input string nm);
        bit found = 1'b0;
        for (int i = 0; i < FRAME_CLK + 20 && !found; i++) begin
            @(negedge clk);
            if (m_run && m_t == target) found = 1'b1;
        end
        check(nm, int'(found), 1);
    endtask

    initial begin
        int n_req, hs_lo, vs_lo, n_ls, n_fs, line_gap, fx, fy, lx, ly;
        tbl[0]  = '{1,  3, 2, 8'hFF, 1};  tbl[1]  = '{1, 17, 2, 8'h00, 0};
        tbl[2]  = '{1,  3, 7, 8'h00, 0};  tbl[3]  = '{2,  0, 0, 8'h00, 1};
        tbl[4]  = '{2,  4, 0, 8'hFF, 1};  tbl[5]  = '{2,  4, 4, 8'h00, 1};
        tbl[6]  = '{2,  0, 4, 8'hFF, 1};  tbl[7]  = '{2,  9, 5, 8'hFF, 1};
        tbl[8]  = '{3,  0, 1, 8'h00, 1};  tbl[9]  = '{3,  2, 1, 8'h49, 1};
        tbl[10] = '{3,  5, 1, 8'h92, 1};  tbl[11] = '{3,  7, 1, 8'hDB, 1};
        tbl[12] = '{3,  8, 1, 8'h24, 1};  tbl[13] = '{3, 11, 1, 8'h6D, 1};
        tbl[14] = '{3, 13, 1, 8'hB6, 1};  tbl[15] = '{3, 15, 1, 8'hFF, 1};
        tbl[16] = '{0,  5, 3, 8'h35, 1};  tbl[17] = '{0, 15, 5, 8'h5F, 1};

        rst = 1'b1; en = 1'b0; mode = 2'd0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rgb", int'(rgb), 0);
        check("rst_h_sync", int'(h_sync), 1);
        check("rst_v_sync", int'(v_sync), 1);
        check("rst_request", int'(pix.request), 0);

        // One full frame in mode 0: counts, periods and first/last request.
        en = 1'b1; mode = 2'd0;
        @(negedge clk);
        check("start_after_en", int'(frame_start), 1);
        n_req = 0; hs_lo = 0; vs_lo = 0; n_ls = 0; n_fs = 0; line_gap = -1;
        fx = -1; fy = -1; lx = -1; ly = -1;
        for (int i = 0; i < FRAME_CLK; i++) begin
            if (pix.request) begin
                if (n_req == 0) begin fx = int'(pix.px_x); fy = int'(pix.px_y); end
                lx = int'(pix.px_x); ly = int'(pix.px_y);
                n_req++;
            end
            if (!h_sync) hs_lo++;
            if (!v_sync) vs_lo++;
            if (line_start) begin
                if (n_ls == 1) line_gap = i;
                n_ls++;
            end
            if (frame_start) n_fs++;
            @(negedge clk);
        end
        check("frame_period", int'(frame_start), 1);
        check("request_count", n_req, HA * VA);
        check("h_sync_low_clks", hs_lo, HS * CD * VT);
        check("v_sync_low_clks", vs_lo, VS * HT * CD);
        check("line_count", n_ls, VT);
        check("line_period", line_gap, HT * CD);
        check("frame_starts", n_fs, 1);
        check("first_px_x", fx, 0);
        check("first_px_y", fy, 0);
        check("last_px_x", lx, HA - 1);
        check("last_px_y", ly, VA - 1);

        foreach (tbl[i]) begin
            restart(tbl[i].md);
            wait_t((tbl[i].y * HT + tbl[i].x + 1) * CD, "tbl_reach");
            check("tbl_rgb", int'(rgb), tbl[i].rgb);
            check("tbl_active", int'(active), tbl[i].act);
        end

        // en dropped mid-line, then raised again.
        restart(1);
        repeat (100 + $urandom_range(0, 40)) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("en0_rgb", int'(rgb), 0);
        check("en0_active", int'(active), 0);
        check("en0_h_sync", int'(h_sync), 1);
        check("en0_v_sync", int'(v_sync), 1);
        check("en0_line_start", int'(line_start), 0);
        en = 1'b1;
        @(negedge clk);
        check("en1_frame_start", int'(frame_start), 1);

        // Random mode changes and enable gaps, checked every cycle by the model.
        for (int it = 0; it < 16; it++) begin
            repeat ($urandom_range(1, 300)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 8)) @(negedge clk);
                en = 1'b1;
            end else begin
                mode = 2'($urandom_range(0, 3));
            end
        end

        // Asynchronous reset in the middle of an active line.
        restart(0);
        wait_t(((3 * HT + 10) * CD) + 1, "reach_rst_point");
        check("px_before_rst", int'(pix.px_x), 10);
        check("rgb_before_rst", int'(rgb), f_col(9, 3));
        #1 rst = 1'b1;
        #1;
        check("arst_rgb", int'(rgb), 0);
        check("arst_active", int'(active), 0);
        check("arst_px_x", int'(pix.px_x), 0);
        check("arst_px_y", int'(pix.px_y), 0);
        check("arst_h_sync", int'(h_sync), 1);
        check("arst_v_sync", int'(v_sync), 1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_frame_start", int'(frame_start), 1);
        repeat (5) @(negedge clk);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
